ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

Consumes PS/2 set-2 scan-code bytes from the keyboard receiver FIFO through its ready/nextdata_n handshake and turns the byte stream into discrete key events. Handles the E0 (extended) and F0 (break) prefixes, tracks modifier and caps-lock state, suppresses typematic repeats, converts printable keys to ASCII and counts distinct key presses. Sits directly downstream of the PS/2 receiver; its outputs feed display and application logic.

## Interface
- CNT_W, default 8: width of the key press counter.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ready  in  1  receiver FIFO non-empty; data valid while high.
- data  in  8  FIFO head byte.
- nextdata_n  out  1  active-low pop strobe to receiver, one cycle wide.
- key_valid  out  1  one-cycle event strobe.
- key_code  out  8  scan code of the event (prefix bytes stripped).
- key_ext  out  1  event was E0-prefixed.
- key_break  out  1  event is a release.
- key_repeat  out  1  make event of a key already held (typematic).
- key_ascii  out  8  ASCII of the event; 0x00 if non-printable, extended or break.
- shift  out  1  either shift held.
- ctrl  out  1  either ctrl held.
- caps  out  1  caps-lock toggle state.
- key_count  out  CNT_W  number of non-repeat, non-modifier make events, wraps.

## Operation
- States: IDLE, ACK, HOLD, PROC.
- IDLE: ready high → latch data into byte_r, drive nextdata_n low (registered), go ACK. ready low → stay.
- ACK: nextdata_n back high, go HOLD. HOLD: one guard cycle so the receiver's ready/data settle, go PROC.
- PROC, by byte_r: 0xE0 → set ext_f; 0xF0 → set brk_f; 0xAA, 0xFA, 0xFE, 0xEE → discard, flags unchanged; otherwise emit event with key_code=byte_r, key_ext=ext_f, key_break=brk_f, then clear both flags. Always return to IDLE.
- Modifiers: 0x12/0x59 (non-ext) set/clear left/right shift; 0x14 (ext or not) sets/clears left/right ctrl; shift = L|R, ctrl = L|R. 0x58 make toggles caps only when not a repeat. Modifier events still pulse key_valid but never change held_r or key_count.
- Repeat: held_r/held_ext_r hold the last non-modifier make. Make matching held → key_repeat=1, no count. Make not matching → key_repeat=0, held updated, key_count+1 (wraps at 2^CNT_W). Break matching held → held cleared (held_valid=0). Break not matching → held unchanged.
- ASCII (make, non-ext only): letters 0x1C→'a', 0x32→'b', 0x21→'c' … full set-2 alphabet, uppercase when shift XOR caps; digits 0x45→'0', 0x16→'1' … 0x46→'9', shift-insensitive; 0x29→0x20, 0x5A→0x0D, 0x66→0x08. All else 0x00.
- Prefix order E0 F0 xx and F0 alone both produce one event; a stray second F0 keeps brk_f set.

## Timing
- Reset: state IDLE, nextdata_n=1, key_valid=0, key_code=0, key_ext=0, key_break=0, key_repeat=0, key_ascii=0, shift=ctrl=caps=0, key_count=0, flags and held cleared.
- ready sampled high in IDLE at cycle n: nextdata_n low during n+1 only; PROC at n+3; event outputs registered, key_valid high at n+4 for exactly one cycle. key_* fields hold until the next event.
- Throughput: one byte per 4 cycles; never pops while ready low; never issues a second pop before HOLD completes.
- shift/ctrl/caps/key_count update in the same cycle key_valid rises.
- Reset mid-sequence (e.g. after E0 consumed) discards partial prefix; no event emitted.

## Structure
- Shared package: scan-code constants (PFX_EXT=0xE0, PFX_BRK=0xF0, SC_LSHIFT, SC_RSHIFT, SC_CTRL, SC_CAPS, ignore codes) and the state enum.
- Sub-module ps2_scan_ascii: combinational lookup (code, ext, shift^caps) → ascii.

## Test plan
- Bytes 1C, F0, 1C → three pops; events: make 0x1C ascii 0x61 count 1, then break 0x1C ascii 0x00 count 1.
- 12, 1C, F0 1C, F0 12 → ascii 0x41, shift high between make/break of 0x12, count 1.
- 1C, 1C, 1C, F0 1C → key_repeat 0,1,1; count 1.
- E0 75, E0 F0 75 → two events, key_ext=1, ascii 0x00, count 1.
- 58, F0 58, 1C → caps=1, ascii 0x41; ready held low → nextdata_n stays 1.
- E0 then rst_n pulse, then 75 → key_ext=0; 256 distinct makes with CNT_W=8 → key_count wraps to 0.

Source files
------------

// File: rtl/ps2_key_decoder_pkg.sv
// Shared scan-code constants, FSM state type and helpers
// for the PS/2 set-2 key decoder.
package ps2_key_decoder_pkg;

   localparam logic [7:0] PFX_EXT   = 8'hE0;
   localparam logic [7:0] PFX_BRK   = 8'hF0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_CAPS   = 8'h58;
   localparam logic [7:0] SC_BAT    = 8'hAA;
   localparam logic [7:0] SC_ACK    = 8'hFA;
   localparam logic [7:0] SC_RESEND = 8'hFE;
   localparam logic [7:0] SC_ECHO   = 8'hEE;

   typedef enum logic [1:0] {
      IDLE,
      ACK,
      HOLD,
      PROC
   } state_t;

   function automatic logic is_ignore(logic [7:0] b);
      return (b == SC_BAT) || (b == SC_ACK) ||
             (b == SC_RESEND) || (b == SC_ECHO);
   endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Receiver FIFO handshake: master = PS/2 receiver, slave = decoder.
// ready/data from the FIFO, nextdata_n active-low pop back to it.
interface ps2_key_decoder_if;
   logic       ready;
   logic [7:0] data;
   logic       nextdata_n;

   modport master (
      output ready,
      output data,
      input  nextdata_n
   );

   modport slave (
      input  ready,
      input  data,
      output nextdata_n
   );
endinterface

// File: rtl/ps2_scan_ascii.sv
// Combinational set-2 scan code to ASCII lookup.
// Ports: code, ext, upper (shift^caps) in; ascii out (0 if none).
module ps2_scan_ascii
   import ps2_key_decoder_pkg::*;
(
   input  logic [7:0] code,
   input  logic       ext,
   input  logic       upper,
   output logic [7:0] ascii
);

   logic [7:0] lc;

   always_comb begin
      lc    = 8'h00;
      ascii = 8'h00;
      case (code)
         8'h1C: lc = "a";
         8'h32: lc = "b";
         8'h21: lc = "c";
         8'h23: lc = "d";
         8'h24: lc = "e";
         8'h2B: lc = "f";
         8'h34: lc = "g";
         8'h33: lc = "h";
         8'h43: lc = "i";
         8'h3B: lc = "j";
         8'h42: lc = "k";
         8'h4B: lc = "l";
         8'h3A: lc = "m";
         8'h31: lc = "n";
         8'h44: lc = "o";
         8'h4D: lc = "p";
         8'h15: lc = "q";
         8'h2D: lc = "r";
         8'h1B: lc = "s";
         8'h2C: lc = "t";
         8'h3C: lc = "u";
         8'h2A: lc = "v";
         8'h1D: lc = "w";
         8'h22: lc = "x";
         8'h35: lc = "y";
         8'h1A: lc = "z";
         8'h45: ascii = "0";
         8'h16: ascii = "1";
         8'h1E: ascii = "2";
         8'h26: ascii = "3";
         8'h25: ascii = "4";
         8'h2E: ascii = "5";
         8'h36: ascii = "6";
         8'h3D: ascii = "7";
         8'h3E: ascii = "8";
         8'h46: ascii = "9";
         8'h29: ascii = 8'h20;
         8'h5A: ascii = 8'h0D;
         8'h66: ascii = 8'h08;
         default: ascii = 8'h00;
      endcase
      // bit 5 separates lower from upper case letters
      if (lc != 8'h00)
         ascii = upper ? (lc ^ 8'h20) : lc;
      if (ext)
         ascii = 8'h00;
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 byte stream to key events with modifiers and repeat filter.
// Ports: clk, rst_n, rx (FIFO slave), key_* event, shift/ctrl/caps, key_count.
module ps2_key_decoder
   import ps2_key_decoder_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   ps2_key_decoder_if.slave rx,
   output logic             key_valid,
   output logic [7:0]       key_code,
   output logic             key_ext,
   output logic             key_break,
   output logic             key_repeat,
   output logic [7:0]       key_ascii,
   output logic             shift,
   output logic             ctrl,
   output logic             caps,
   output logic [CNT_W-1:0] key_count
);

   state_t     state, state_nxt;
   logic       pop_nxt;
   logic       nextdata_n_r;
   logic [7:0] byte_r;
   logic       ext_f, brk_f;
   logic [7:0] held_r;
   logic       held_ext_r, held_valid;
   logic       lshift, rshift, lctrl, rctrl;

   logic       is_pe, is_pb, is_ign;
   logic       is_ls, is_rs, is_ct, is_mod;
   logic       mk, hit;
   logic [7:0] ascii_w;

   assign rx.nextdata_n = nextdata_n_r;
   assign shift = lshift | rshift;
   assign ctrl  = lctrl | rctrl;

   assign is_pe  = byte_r == PFX_EXT;
   assign is_pb  = byte_r == PFX_BRK;
   assign is_ign = is_ignore(byte_r);
   assign is_ls  = !ext_f && byte_r == SC_LSHIFT;
   assign is_rs  = !ext_f && byte_r == SC_RSHIFT;
   assign is_ct  = byte_r == SC_CTRL;
   assign is_mod = is_ls | is_rs | is_ct;
   assign mk     = !brk_f;
   assign hit    = held_valid && held_r == byte_r &&
                   held_ext_r == ext_f;

   ps2_scan_ascii u_ascii (
      .code  (byte_r),
      .ext   (ext_f),
      .upper (shift ^ caps),
      .ascii (ascii_w)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop_nxt   = 1'b0;
      unique case (state)
         IDLE: begin
            if (rx.ready) begin
               state_nxt = ACK;
               pop_nxt   = 1'b1;
            end
         end
         ACK:     state_nxt = HOLD;
         HOLD:    state_nxt = PROC;
         PROC:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nextdata_n_r <= 1'b1;
         byte_r       <= 8'h00;
         ext_f        <= 1'b0;
         brk_f        <= 1'b0;
         held_r       <= 8'h00;
         held_ext_r   <= 1'b0;
         held_valid   <= 1'b0;
         lshift       <= 1'b0;
         rshift       <= 1'b0;
         lctrl        <= 1'b0;
         rctrl        <= 1'b0;
         caps         <= 1'b0;
         key_count    <= '0;
         key_valid    <= 1'b0;
         key_code     <= 8'h00;
         key_ext      <= 1'b0;
         key_break    <= 1'b0;
         key_repeat   <= 1'b0;
         key_ascii    <= 8'h00;
      end else begin
         nextdata_n_r <= !pop_nxt;
         key_valid    <= 1'b0;
         if (pop_nxt)
            byte_r <= rx.data;
         if (state == PROC) begin
            unique case (1'b1)
               is_pe:  ext_f <= 1'b1;
               is_pb:  brk_f <= 1'b1;
               is_ign: begin
               end
               default: begin
                  key_valid  <= 1'b1;
                  key_code   <= byte_r;
                  key_ext    <= ext_f;
                  key_break  <= brk_f;
                  key_repeat <= mk && !is_mod && hit;
                  key_ascii  <= mk ? ascii_w : 8'h00;
                  ext_f      <= 1'b0;
                  brk_f      <= 1'b0;
                  if (is_ls) lshift <= mk;
                  if (is_rs) rshift <= mk;
                  if (is_ct && ext_f)  rctrl <= mk;
                  if (is_ct && !ext_f) lctrl <= mk;
                  // modifiers bypass the repeat filter
                  if (!is_mod) begin
                     if (mk && !hit) begin
                        held_r     <= byte_r;
                        held_ext_r <= ext_f;
                        held_valid <= 1'b1;
                        key_count  <= key_count + CNT_W'(1);
                        if (!ext_f && byte_r == SC_CAPS)
                           caps <= !caps;
                     end else if (!mk && hit) begin
                        held_valid <= 1'b0;
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized + directed bench for ps2_key_decoder against
// a behavioural key-event model.
module tb_ps2_key_decoder;

   localparam int CNT_W = 8;
   localparam int CMOD  = 1 << CNT_W;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             key_valid, key_ext, key_break, key_repeat;
   logic [7:0]       key_code, key_ascii;
   logic             shift, ctrl, caps;
   logic [CNT_W-1:0] key_count;

   ps2_key_decoder_if rx ();

   ps2_key_decoder #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .key_ext    (key_ext),
      .key_break  (key_break),
      .key_repeat (key_repeat),
      .key_ascii  (key_ascii),
      .shift      (shift),
      .ctrl       (ctrl),
      .caps       (caps),
      .key_count  (key_count)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h t=%0t",
                    tag, got, exp, $time);
   endtask

   // ---------------- reference model ----------------
   byte unsigned lt[26] = '{
      8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
      8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
      8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   byte unsigned dg[10] = '{
      8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
      8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

   bit m_ext, m_brk, m_hv, m_ls, m_rs, m_lc, m_rc, m_caps;
   int m_held, m_cnt;

   logic [7:0] e_code, e_asc;
   bit e_ext, e_brk, e_rep;

   function automatic logic [7:0] ref_ascii(logic [7:0] c,
                                            bit up);
      for (int i = 0; i < 26; i++)
         if (lt[i] == c) return up ? 8'd65 + 8'(i) : 8'd97 + 8'(i);
      for (int i = 0; i < 10; i++)
         if (dg[i] == c) return 8'd48 + 8'(i);
      if (c == 8'h29) return 8'h20;
      if (c == 8'h5A) return 8'h0D;
      if (c == 8'h66) return 8'h08;
      return 8'h00;
   endfunction

   task automatic ref_reset();
      {m_ext, m_brk, m_hv, m_ls, m_rs, m_lc, m_rc, m_caps} = '0;
      m_held = -1;
      m_cnt  = 0;
      e_code = 0; e_asc = 0;
      {e_ext, e_brk, e_rep} = '0;
   endtask

   task automatic ref_step(input logic [7:0] b, output bit ev);
      int  key;
      bit  mod, same, make;
      ev = 0;
      if (b == 8'hE0) begin m_ext = 1; return; end
      if (b == 8'hF0) begin m_brk = 1; return; end
      if (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE}) return;
      ev   = 1;
      key  = (m_ext ? 256 : 0) + int'(b);
      mod  = (!m_ext && (b == 8'h12 || b == 8'h59)) || b == 8'h14;
      same = m_hv && m_held == key;
      make = !m_brk;
      e_code = b;
      e_ext  = m_ext;
      e_brk  = m_brk;
      e_rep  = make && !mod && same;
      e_asc  = (make && !m_ext) ?
               ref_ascii(b, (m_ls | m_rs) ^ m_caps) : 8'h00;
      if (mod) begin
         if (b == 8'h12) m_ls = make;
         if (b == 8'h59) m_rs = make;
         if (b == 8'h14) begin
            if (m_ext) m_rc = make;
            else       m_lc = make;
         end
      end else if (make && !same) begin
         m_held = key;
         m_hv   = 1;
         m_cnt  = (m_cnt + 1) % CMOD;
         if (b == 8'h58 && !m_ext) m_caps = !m_caps;
      end else if (!make && same) begin
         m_hv = 0;
      end
      m_ext = 0;
      m_brk = 0;
   endtask

   // ---------------- driver ----------------
   task automatic send(input logic [7:0] b);
      bit popped;
      int lat;
      bit ev;
      popped = 0;
      lat    = 0;
      rx.ready = 1'b1;
      rx.data  = b;
      for (int i = 1; i <= 8 && !popped; i++) begin
         @(posedge clk); #1;
         if (!rx.nextdata_n) begin popped = 1; lat = i; end
      end
      chk("pop_seen", 32'(popped), 1);
      if (!popped) begin
         rx.ready = 1'b0;
         return;
      end
      chk("pop_lat", lat, 1);
      chk("kv_pulse", 32'(key_valid), 0);
      @(posedge clk); #1;
      rx.ready = 1'b0;
      rx.data  = 8'($urandom);
      chk("pop_width", 32'(rx.nextdata_n), 1);
      ref_step(b, ev);
      @(posedge clk);
      @(posedge clk); #1;
      chk("kv", 32'(key_valid), 32'(ev));
      if (ev) begin
         chk("code", 32'(key_code), 32'(e_code));
         chk("ext", 32'(key_ext), 32'(e_ext));
         chk("brk", 32'(key_break), 32'(e_brk));
         chk("rep", 32'(key_repeat), 32'(e_rep));
         chk("ascii", 32'(key_ascii), 32'(e_asc));
      end else begin
         chk("hold", 32'(key_code), 32'(e_code));
      end
      chk("shift", 32'(shift), 32'(m_ls | m_rs));
      chk("ctrl", 32'(ctrl), 32'(m_lc | m_rc));
      chk("caps", 32'(caps), 32'(m_caps));
      chk("count", 32'(key_count), 32'(m_cnt));
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n    = 1'b0;
      rx.ready = 1'b0;
      rx.data  = 8'h00;
      ref_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   byte unsigned pool[22] = '{
      8'h1C, 8'h32, 8'h21, 8'h1A, 8'h45, 8'h16, 8'h46,
      8'h29, 8'h5A, 8'h66, 8'h12, 8'h59, 8'h14, 8'h58,
      8'hE0, 8'hF0, 8'hF0, 8'hAA, 8'hFA, 8'h75, 8'h6B,
      8'hEE};

   initial begin
      bit bad;
      rx.ready = 1'b0;
      rx.data  = 8'h00;
      do_reset();
      chk("rst_nd", 32'(rx.nextdata_n), 1);
      chk("rst_kv", 32'(key_valid), 0);
      chk("rst_fields",
          32'({key_code, key_ascii, key_ext, key_break, key_repeat}), 0);
      chk("rst_mods", 32'({shift, ctrl, caps}), 0);
      chk("rst_cnt", 32'(key_count), 0);

      send(8'h1C); send(8'hF0); send(8'h1C);
      chk("tp1_cnt", 32'(key_count), 1);

      do_reset();
      send(8'h12); send(8'h1C);
      chk("tp2_ascii", 32'(key_ascii), 32'h41);
      send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
      chk("tp2_shift", 32'(shift), 0);

      do_reset();
      send(8'h1C); send(8'h1C);
      chk("tp3_rep", 32'(key_repeat), 1);
      send(8'h1C); send(8'hF0); send(8'h1C);

      do_reset();
      send(8'hE0); send(8'h75);
      send(8'hE0); send(8'hF0); send(8'h75);
      chk("tp4_ext", 32'(key_ext), 1);

      do_reset();
      send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
      chk("tp5_ascii", 32'(key_ascii), 32'h41);

      bad = 0;
      rx.ready = 1'b0;
      rx.data  = 8'h1C;
      repeat (20) begin
         @(posedge clk); #1;
         if (!rx.nextdata_n) bad = 1;
      end
      chk("no_pop_idle", 32'(bad), 0);

      send(8'hE0);
      do_reset();
      send(8'h75);
      chk("rst_mid_ext", 32'(key_ext), 0);

      do_reset();
      for (int i = 0; i < CMOD; i++)
         send((i % 2) ? 8'h32 : 8'h1C);
      chk("wrap", 32'(key_count), 0);

      do_reset();
      for (int i = 0; i < 300; i++)
         send(pool[$urandom_range(0, 21)]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
